// File: rtl/prescaler_timer_ctrl_if.sv
// Bus between the CPU-side timer registers, the prescaler and prescaler_timer_ctrl.
// The controller connects through the slave modport; dbg_state mirrors its FSM state.
interface prescaler_timer_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             i_Start;
  logic             i_Stop;
  logic             i_Periodic;
  logic [31:0]      i_Div;
  logic [CNT_W-1:0] i_Count;
  logic             i_Timming;
  logic [31:0]      o_Frec_de_trabajo;
  logic             o_Pre_Rst;
  logic             o_Busy;
  logic             o_Expired;
  logic             o_Err;
  logic [CNT_W-1:0] o_Remaining;
  logic [1:0]       dbg_state;

  // Handshake: i_Start and i_Stop are single-cycle command pulses sampled on
  // the rising clock edge with no ready/backpressure; i_Stop beats i_Start.
  // o_Expired is a one-cycle event pulse that is never held or acknowledged.
  modport slave (
    input  i_Start, i_Stop, i_Periodic, i_Div, i_Count, i_Timming,
    output o_Frec_de_trabajo, o_Pre_Rst, o_Busy, o_Expired, o_Err, o_Remaining,
    output dbg_state
  );

  modport master (
    output i_Start, i_Stop, i_Periodic, i_Div, i_Count, i_Timming,
    input  o_Frec_de_trabajo, o_Pre_Rst, o_Busy, o_Expired, o_Err, o_Remaining,
    input  dbg_state
  );
endinterface

// File: rtl/prescaler_timer_ctrl.sv
// Sequencer for the shared prescaler: programs and resets it, counts its tick
// edges and raises expiry events in one-shot or periodic mode.
module prescaler_timer_ctrl #(
  parameter int CNT_W      = 16,
  parameter int PRE_RST_CY = 2
) (
  input logic               i_Clk,
  input logic               i_Rst,
  prescaler_timer_ctrl_if.slave bus
);

  localparam int PW = (PRE_RST_CY > 1) ? $clog2(PRE_RST_CY) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRE_RST_CY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [31:0]      frec;
  logic             pre_rst;
  logic             busy;
  logic             expired;
  logic             err;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] count_q;
  logic             periodic_q;
  logic [PW-1:0]    pre_cnt;
  logic             prev;

  logic tick;
  logic start_illegal;

  assign tick          = bus.i_Timming & ~prev;
  assign start_illegal = (bus.i_Div == 32'd0) || (bus.i_Count == '0);

  // prev samples i_Timming in every state, so a level that is already high
  // when the prescaler leaves reset is not mistaken for a tick.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state      <= IDLE;
      frec       <= 32'd0;
      pre_rst    <= 1'b1;
      busy       <= 1'b0;
      expired    <= 1'b0;
      err        <= 1'b0;
      remaining  <= '0;
      count_q    <= '0;
      periodic_q <= 1'b0;
      pre_cnt    <= '0;
      prev       <= 1'b0;
    end else begin
      prev    <= bus.i_Timming;
      expired <= 1'b0;
      if (bus.i_Stop) begin
        state     <= IDLE;
        remaining <= '0;
        busy      <= 1'b0;
        pre_rst   <= 1'b1;
      end else if (bus.i_Start) begin
        if (start_illegal) begin
          err       <= 1'b1;
          state     <= IDLE;
          remaining <= '0;
          busy      <= 1'b0;
          pre_rst   <= 1'b1;
        end else begin
          err        <= 1'b0;
          frec       <= bus.i_Div;
          count_q    <= bus.i_Count;
          periodic_q <= bus.i_Periodic;
          remaining  <= bus.i_Count;
          pre_cnt    <= '0;
          state      <= LOAD;
          busy       <= 1'b1;
          pre_rst    <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            pre_rst <= 1'b1;
            busy    <= 1'b0;
          end
          LOAD: begin
            if (pre_cnt == PRE_LAST) begin
              state   <= RUN;
              pre_rst <= 1'b0;
            end else begin
              pre_cnt <= pre_cnt + 1'b1;
            end
          end
          RUN: begin
            if (tick) begin
              if (remaining > CNT_W'(1)) begin
                remaining <= remaining - 1'b1;
              end else begin
                remaining <= '0;
                expired   <= 1'b1;
                state     <= DONE;
              end
            end
          end
          DONE: begin
            if (periodic_q) begin
              // Prescaler keeps running; a tick landing here opens the new period.
              if (tick && count_q == CNT_W'(1)) begin
                remaining <= '0;
                expired   <= 1'b1;
                state     <= DONE;
              end else if (tick) begin
                remaining <= count_q - 1'b1;
                state     <= RUN;
              end else begin
                remaining <= count_q;
                state     <= RUN;
              end
            end else begin
              state   <= IDLE;
              busy    <= 1'b0;
              pre_rst <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.o_Frec_de_trabajo = frec;
  assign bus.o_Pre_Rst         = pre_rst;
  assign bus.o_Busy            = busy;
  assign bus.o_Expired         = expired;
  assign bus.o_Err             = err;
  assign bus.o_Remaining       = remaining;
  assign bus.dbg_state         = state;

endmodule

// File: tb/tb_prescaler_timer_ctrl.sv
// Directed bench for prescaler_timer_ctrl: a cycle table of hand-computed
// vectors plus sequences for periodic reload and asynchronous reset.
module tb_prescaler_timer_ctrl;
  localparam int CNT_W = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   passes;

  prescaler_timer_ctrl_if #(.CNT_W(CNT_W)) bus ();

  prescaler_timer_ctrl #(.CNT_W(CNT_W), .PRE_RST_CY(2)) dut (
    .i_Clk (clk),
    .i_Rst (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        sp;
    logic        per;
    logic [31:0] div;
    logic [15:0] cnt;
    logic        tm;
    logic [1:0]  e_state;
    logic        e_busy;
    logic        e_pre;
    logic        e_exp;
    logic        e_err;
    logic [15:0] e_rem;
    logic [31:0] e_frec;
  } vec_t;

  vec_t vecs[35];

  function automatic vec_t mk(input logic st, input logic sp, input logic per,
                              input logic [31:0] div, input logic [15:0] cnt,
                              input logic tm, input logic [1:0] s, input logic b,
                              input logic p, input logic e, input logic r,
                              input logic [15:0] rem, input logic [31:0] fr);
    vec_t v;
    v.st = st; v.sp = sp; v.per = per; v.div = div; v.cnt = cnt; v.tm = tm;
    v.e_state = s; v.e_busy = b; v.e_pre = p; v.e_exp = e; v.e_err = r;
    v.e_rem = rem; v.e_frec = fr;
    return v;
  endfunction

  function automatic logic [63:0] pack_outs();
    return {10'd0, bus.dbg_state, bus.o_Busy, bus.o_Pre_Rst, bus.o_Expired,
            bus.o_Err, bus.o_Remaining, bus.o_Frec_de_trabajo};
  endfunction

  function automatic logic [63:0] pack_exp(input logic [1:0] s, input logic b,
                                           input logic p, input logic e,
                                           input logic r, input logic [15:0] rem,
                                           input logic [31:0] fr);
    return {10'd0, s, b, p, e, r, rem, fr};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic drive(input logic st, input logic sp, input logic per,
                       input logic [31:0] div, input logic [15:0] cnt, input logic tm);
    bus.i_Start    = st;
    bus.i_Stop     = sp;
    bus.i_Periodic = per;
    bus.i_Div      = div;
    bus.i_Count    = cnt;
    bus.i_Timming  = tm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];

  initial begin
    logic [15:0] last_rem;
    logic [7:0]  pcnt;
    logic        new_tm;
    int          edges;
    int          n_exp;
    int          cyc;
    int          pre_glitch;
    logic        released;

    checks = 0;
    passes = 0;

    vecs[0]  = mk(1,0,0,8,3,0, 1,1,1,0,0,3,8);
    vecs[1]  = mk(0,0,0,0,0,0, 1,1,1,0,0,3,8);
    vecs[2]  = mk(0,0,0,0,0,0, 2,1,0,0,0,3,8);
    vecs[3]  = mk(0,0,0,0,0,1, 2,1,0,0,0,2,8);
    vecs[4]  = mk(0,0,0,0,0,1, 2,1,0,0,0,2,8);
    vecs[5]  = mk(0,0,0,0,0,0, 2,1,0,0,0,2,8);
    vecs[6]  = mk(0,0,0,0,0,1, 2,1,0,0,0,1,8);
    vecs[7]  = mk(0,0,0,0,0,0, 2,1,0,0,0,1,8);
    vecs[8]  = mk(0,0,0,0,0,1, 3,1,0,1,0,0,8);
    vecs[9]  = mk(0,0,0,0,0,0, 0,0,1,0,0,0,8);
    vecs[10] = mk(0,0,0,0,0,0, 0,0,1,0,0,0,8);
    vecs[11] = mk(1,0,0,0,5,0, 0,0,1,0,1,0,8);
    vecs[12] = mk(1,0,0,4,0,0, 0,0,1,0,1,0,8);
    vecs[13] = mk(1,0,0,4,1,0, 1,1,1,0,0,1,4);
    vecs[14] = mk(0,0,0,0,0,1, 1,1,1,0,0,1,4);
    vecs[15] = mk(0,0,0,0,0,1, 2,1,0,0,0,1,4);
    vecs[16] = mk(0,0,0,0,0,1, 2,1,0,0,0,1,4);
    vecs[17] = mk(0,0,0,0,0,0, 2,1,0,0,0,1,4);
    vecs[18] = mk(0,0,0,0,0,1, 3,1,0,1,0,0,4);
    vecs[19] = mk(0,0,0,0,0,0, 0,0,1,0,0,0,4);
    vecs[20] = mk(1,0,0,6,2,0, 1,1,1,0,0,2,6);
    vecs[21] = mk(0,0,0,0,0,0, 1,1,1,0,0,2,6);
    vecs[22] = mk(0,0,0,0,0,0, 2,1,0,0,0,2,6);
    vecs[23] = mk(0,0,0,0,0,1, 2,1,0,0,0,1,6);
    vecs[24] = mk(0,1,0,0,0,0, 0,0,1,0,0,0,6);
    vecs[25] = mk(1,1,0,9,4,1, 0,0,1,0,0,0,6);
    vecs[26] = mk(1,0,0,6,3,0, 1,1,1,0,0,3,6);
    vecs[27] = mk(0,0,0,0,0,0, 1,1,1,0,0,3,6);
    vecs[28] = mk(0,0,0,0,0,0, 2,1,0,0,0,3,6);
    vecs[29] = mk(0,0,0,0,0,1, 2,1,0,0,0,2,6);
    vecs[30] = mk(1,0,0,7,5,0, 1,1,1,0,0,5,7);
    vecs[31] = mk(0,0,0,0,0,1, 1,1,1,0,0,5,7);
    vecs[32] = mk(0,0,0,0,0,1, 2,1,0,0,0,5,7);
    vecs[33] = mk(1,0,0,0,5,1, 0,0,1,0,1,0,7);
    vecs[34] = mk(0,1,0,0,0,0, 0,0,1,0,1,0,7);

    // Clock/reset
    drive(0,0,0,0,0,0);
    rst_n = 1'b0;
    #12;
    check("reset_values", pack_outs(), pack_exp(0,0,1,0,0,0,0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("idle_after_reset", pack_outs(), pack_exp(0,0,1,0,0,0,0));

    // One-shot, illegal starts, held tick level, stop/restart
    for (int i = 0; i < 35; i++) begin
      drive(vecs[i].st, vecs[i].sp, vecs[i].per, vecs[i].div, vecs[i].cnt, vecs[i].tm);
      step();
      check($sformatf("vec%0d", i), pack_outs(),
            pack_exp(vecs[i].e_state, vecs[i].e_busy, vecs[i].e_pre, vecs[i].e_exp,
                     vecs[i].e_err, vecs[i].e_rem, vecs[i].e_frec));
    end

    // Periodic Div=8 Count=2 against a modelled prescaler (tick every 8 cycles)
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(16'd2);
      exp_q.push_back(16'd1);
      exp_q.push_back(16'd0);
    end
    drive(1,0,1,8,2,0);
    step();
    drive(0,0,0,0,0,0);
    last_rem = 16'd0;
    pcnt = 8'd0;
    edges = 0;
    n_exp = 0;
    cyc = 0;
    pre_glitch = 0;
    released = 1'b0;
    while (n_exp < 5 && cyc < 400) begin
      if (bus.o_Remaining !== last_rem) begin
        obs_q.push_back(bus.o_Remaining);
        last_rem = bus.o_Remaining;
      end
      if (bus.o_Expired) begin
        check($sformatf("per_ticks%0d", n_exp), 64'(edges), 64'd2);
        edges = 0;
        n_exp++;
      end
      if (released && bus.o_Pre_Rst) pre_glitch++;
      if (!bus.o_Pre_Rst) released = 1'b1;
      if (bus.o_Pre_Rst) pcnt = 8'd0;
      else pcnt = pcnt + 8'd1;
      new_tm = pcnt[2];
      if (new_tm && !bus.i_Timming) edges++;
      bus.i_Timming = new_tm;
      step();
      cyc++;
    end
    check("per_expiries", 64'(n_exp), 64'd5);
    check("per_no_pre_rst", 64'(pre_glitch), 64'd0);
    check("per_rem_len", 64'(obs_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
      check($sformatf("per_rem%0d", k), 64'(obs_q[k]), 64'(exp_q[k]));
    drive(0,1,0,0,0,0);
    step();
    drive(0,0,0,0,0,0);
    check("per_stop", pack_outs(), pack_exp(0,0,1,0,0,0,8));

    // Asynchronous reset in the middle of RUN
    drive(1,0,0,4,5,0);
    step();
    drive(0,0,0,0,0,0);
    step();
    step();
    step();
    check("pre_reset_run", pack_outs(), pack_exp(2,1,0,0,0,5,4));
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", pack_outs(), pack_exp(0,0,1,0,0,0,0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("idle_after_rerst", pack_outs(), pack_exp(0,0,1,0,0,0,0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
